// File: rtl/vector_list_sequencer.sv
// Display-list sequencer: fetches list words from synchronous-read memory and issues
// jump/draw strobes to the vector control block, replaying the list every frame.
module vector_list_sequencer #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_data,
  input  logic              ready,
  output logic [11:0]       x,
  output logic [11:0]       y,
  output logic              jump,
  output logic              draw,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              halted,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_ISSUE, S_HOLDOFF, S_HALTED
  } state_t;

  localparam logic [1:0] OP_JUMP = 2'b00;
  localparam logic [1:0] OP_DRAW = 2'b01;
  localparam logic [1:0] OP_EOF  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic              r_rd, w_rd_next;
  logic [11:0]       r_x, w_x_next, r_y, w_y_next;
  logic              r_jump, w_jump_next, r_draw, w_draw_next;
  logic              r_frame_done, w_frame_done_next;
  logic [15:0]       r_frame_count, w_frame_count_next;
  logic              r_halted, w_halted_next;
  logic              r_busy, w_busy_next;
  logic              r_cmd_draw, w_cmd_draw_next;
  logic [11:0]       r_cmd_x, w_cmd_x_next, r_cmd_y, w_cmd_y_next;
  logic              w_unused_bits;

  // Reserved word bits [29:24] carry no meaning.
  assign w_unused_bits = ^mem_data[29:24];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_rd          <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_jump        <= 1'b0;
      r_draw        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_halted      <= 1'b0;
      r_busy        <= 1'b0;
      r_cmd_draw    <= 1'b0;
      r_cmd_x       <= '0;
      r_cmd_y       <= '0;
    end else begin
      r_state       <= w_state_next;
      r_addr        <= w_addr_next;
      r_rd          <= w_rd_next;
      r_x           <= w_x_next;
      r_y           <= w_y_next;
      r_jump        <= w_jump_next;
      r_draw        <= w_draw_next;
      r_frame_done  <= w_frame_done_next;
      r_frame_count <= w_frame_count_next;
      r_halted      <= w_halted_next;
      r_busy        <= w_busy_next;
      r_cmd_draw    <= w_cmd_draw_next;
      r_cmd_x       <= w_cmd_x_next;
      r_cmd_y       <= w_cmd_y_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_addr_next        = r_addr;
    w_x_next           = r_x;
    w_y_next           = r_y;
    w_jump_next        = 1'b0;
    w_draw_next        = 1'b0;
    w_frame_done_next  = 1'b0;
    w_frame_count_next = r_frame_count;
    w_halted_next      = r_halted;
    w_cmd_draw_next    = r_cmd_draw;
    w_cmd_x_next       = r_cmd_x;
    w_cmd_y_next       = r_cmd_y;

    case (r_state)
      S_IDLE: begin
        w_addr_next = '0;
        if (enable) w_state_next = S_FETCH;
      end
      S_FETCH: w_state_next = S_LATCH;
      S_LATCH: begin
        w_cmd_draw_next = mem_data[30];
        w_cmd_x_next    = mem_data[23:12];
        w_cmd_y_next    = mem_data[11:0];
        case (mem_data[31:30])
          OP_JUMP, OP_DRAW: w_state_next = S_ISSUE;
          OP_EOF: begin
            w_frame_done_next  = 1'b1;
            w_frame_count_next = r_frame_count + 16'd1;
            w_addr_next        = '0;
            w_state_next       = enable ? S_FETCH : S_IDLE;
          end
          OP_HALT: begin
            w_halted_next = 1'b1;
            w_state_next  = S_HALTED;
          end
        endcase
      end
      S_ISSUE: begin
        if (ready) begin
          w_x_next     = r_cmd_x;
          w_y_next     = r_cmd_y;
          w_jump_next  = ~r_cmd_draw;
          w_draw_next  = r_cmd_draw;
          w_addr_next  = r_addr + ADDR_W'(1);
          w_state_next = S_HOLDOFF;
          // Running off the end of the list closes the frame like an EOF word.
          if (&r_addr) begin
            w_frame_done_next  = 1'b1;
            w_frame_count_next = r_frame_count + 16'd1;
          end
        end
      end
      S_HOLDOFF: begin
        if (enable) begin
          w_state_next = S_FETCH;
        end else begin
          w_state_next = S_IDLE;
          w_addr_next  = '0;
        end
      end
      S_HALTED: begin
        if (!enable) begin
          w_state_next  = S_IDLE;
          w_halted_next = 1'b0;
          w_addr_next   = '0;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    w_rd_next   = (w_state_next == S_FETCH);
    w_busy_next = !((w_state_next == S_IDLE) || (w_state_next == S_HALTED));
  end

  assign mem_addr    = r_addr;
  assign mem_rd      = r_rd;
  assign x           = r_x;
  assign y           = r_y;
  assign jump        = r_jump;
  assign draw        = r_draw;
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;
  assign halted      = r_halted;
  assign busy        = r_busy;

endmodule

// File: tb/tb_vector_list_sequencer.sv
// Bench for vector_list_sequencer: a list-walking model checks every strobe/frame event,
// plus directed literal checks for latency, backpressure, HALT, wrap and reset.
module tb_vector_list_sequencer;

  localparam int EV_STROBE = 0;
  localparam int EV_FD     = 1;
  localparam int EV_IDLE   = 3;
  localparam int EV_RD     = 4;
  localparam int EV_WRD    = 6;
  localparam int EV_WIDLE  = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, enable_w, ready;
  logic [9:0]  mem_addr;
  logic        mem_rd;
  logic [31:0] mem_data = '0;
  logic [11:0] x, y;
  logic        jump, draw, frame_done, halted, busy;
  logic [15:0] frame_count;

  logic [1:0]  wr_mem_addr;
  logic        wr_mem_rd;
  logic [31:0] wr_mem_data = '0;
  logic [11:0] wr_x, wr_y;
  logic        wr_jump, wr_draw, wr_frame_done, wr_halted, wr_busy;
  logic [15:0] wr_frame_count;

  logic [31:0] mem    [0:1023];
  logic [31:0] wr_mem [0:3];

  vector_list_sequencer u_dut (
    .clk(clk), .reset(reset), .enable(enable),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .ready(ready), .x(x), .y(y), .jump(jump), .draw(draw),
    .frame_done(frame_done), .frame_count(frame_count),
    .halted(halted), .busy(busy)
  );

  vector_list_sequencer #(.ADDR_W(2)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable_w),
    .mem_addr(wr_mem_addr), .mem_rd(wr_mem_rd), .mem_data(wr_mem_data),
    .ready(ready), .x(wr_x), .y(wr_y), .jump(wr_jump), .draw(wr_draw),
    .frame_done(wr_frame_done), .frame_count(wr_frame_count),
    .halted(wr_halted), .busy(wr_busy)
  );

  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];
  always @(posedge clk) if (wr_mem_rd) wr_mem_data <= wr_mem[wr_mem_addr];

  int vectors = 0;
  int miscompares = 0;
  int m_pc = 0;
  int m_count = 0;
  logic cmp_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] op, input logic [11:0] xx, input logic [11:0] yy);
    return {op, 6'b101010, xx, yy};
  endfunction

  // Walks the display list one visible event at a time: a strobe, a lone EOF pulse, or HALT.
  task automatic model_next(output int kind, output logic [11:0] ex, output logic [11:0] ey,
                            output logic efd);
    logic [31:0] wd;
    wd   = mem[m_pc];
    kind = int'(wd[31:30]);
    ex   = wd[23:12];
    ey   = wd[11:0];
    efd  = 1'b0;
    if (kind <= 1) begin
      efd  = (m_pc == 1023);
      m_pc = (m_pc + 1) % 1024;
    end else if (kind == 2) begin
      efd  = 1'b1;
      m_pc = 0;
    end
    if (efd) m_count = (m_count + 1) % 65536;
  endtask

  logic        p_strobe = 1'b0, p_fd = 1'b0, p_halted = 1'b0;
  logic [11:0] p_x = '0, p_y = '0;

  initial begin : compare
    int kind;
    logic [11:0] ex, ey;
    logic efd;
    forever begin
      @(negedge clk);
      if (reset && cmp_on) begin
        check("strobe_exclusive", 32'(jump & draw), 32'd0);
        if (p_strobe) check("strobe_gap", 32'(jump | draw), 32'd0);
        if (p_fd) check("frame_done_gap", 32'(frame_done), 32'd0);
        if (!(jump | draw)) begin
          check("x_hold", 32'(x), 32'(p_x));
          check("y_hold", 32'(y), 32'(p_y));
        end
        if (halted) check("halted_not_busy", 32'(busy), 32'd0);
        if (jump | draw | frame_done | (halted & ~p_halted)) begin
          model_next(kind, ex, ey, efd);
          if (jump | draw) begin
            check("model_kind", 32'(draw), 32'(kind));
            check("model_x", 32'(x), 32'(ex));
            check("model_y", 32'(y), 32'(ey));
            check("model_fd", 32'(frame_done), 32'(efd));
          end else if (frame_done) begin
            check("model_eof", 32'd2, 32'(kind));
          end else begin
            check("model_halt", 32'd3, 32'(kind));
          end
        end
        check("model_count", 32'(frame_count), 32'(m_count));
      end
      p_strobe = jump | draw;
      p_fd     = frame_done;
      p_halted = halted;
      p_x      = x;
      p_y      = y;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic ev_cond(input int which);
    case (which)
      EV_STROBE: return jump | draw;
      EV_FD:     return frame_done;
      EV_IDLE:   return ~busy;
      EV_RD:     return mem_rd;
      EV_WRD:    return wr_mem_rd;
      EV_WIDLE:  return ~wr_busy;
      default:   return 1'b0;
    endcase
  endfunction

  task automatic wait_ev(input string name, input int which, input int maxc, output int n);
    n = 0;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (ev_cond(which)) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: timeout, event absent after %0d cycles, required within bound", name, maxc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    int n, draws, stray, k;
    for (int i = 0; i < 1024; i++) mem[i] = mk(2'b11, 12'h0, 12'h0);
    mem[0] = mk(2'b00, 12'h100, 12'h200);
    mem[1] = mk(2'b01, 12'hFFF, 12'h000);
    mem[2] = mk(2'b10, 12'h000, 12'h000);
    for (int i = 0; i < 4; i++) wr_mem[i] = mk(2'b01, 12'(i + 1), 12'(i + 16));

    reset = 1'b1; enable = 1'b0; enable_w = 1'b0; ready = 1'b1;
    #1 reset = 1'b0;
    repeat (3) tick();
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_x", 32'(x), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_jump", 32'(jump), 32'd0);
    check("rst_draw", 32'(draw), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    tick();
    cmp_on = 1'b1;

    // Basic sequence: JUMP, DRAW, EOF replayed
    enable = 1'b1;
    tick();
    check("fetch_rd", 32'(mem_rd), 32'd1);
    check("fetch_addr", 32'(mem_addr), 32'd0);
    check("fetch_busy", 32'(busy), 32'd1);
    wait_ev("first_strobe", EV_STROBE, 20, n);
    check("first_latency", 32'(n), 32'd3);
    check("first_jump", 32'(jump), 32'd1);
    check("first_x", 32'(x), 32'h100);
    check("first_y", 32'(y), 32'h200);
    wait_ev("second_strobe", EV_STROBE, 20, n);
    check("cmd_spacing", 32'(n), 32'd4);
    check("second_draw", 32'(draw), 32'd1);
    check("second_x", 32'(x), 32'hFFF);
    check("second_y", 32'(y), 32'h000);
    wait_ev("eof_pulse", EV_FD, 20, n);
    check("eof_delay", 32'(n), 32'd3);
    check("count_after_1", 32'(frame_count), 32'd1);
    wait_ev("eof_pulse2", EV_FD, 20, n);
    wait_ev("eof_pulse3", EV_FD, 20, n);
    check("count_after_3", 32'(frame_count), 32'd3);
    enable = 1'b0;
    wait_ev("basic_stop", EV_IDLE, 20, n);
    m_pc = 0;
    check("idle_addr", 32'(mem_addr), 32'd0);

    // HOLDOFF window and 50-cycle backpressure on the DRAW
    enable = 1'b1;
    wait_ev("bp_jump", EV_STROBE, 20, n);
    check("bp_jump_seen", 32'(jump), 32'd1);
    ready = 1'b0;
    stray = 0;
    repeat (50) begin
      tick();
      if (jump | draw) stray++;
    end
    check("bp_no_strobe", 32'(stray), 32'd0);
    check("bp_x_hold", 32'(x), 32'h100);
    check("bp_y_hold", 32'(y), 32'h200);
    ready = 1'b1;
    wait_ev("bp_release", EV_STROBE, 5, n);
    check("bp_release_delay", 32'(n), 32'd1);
    check("bp_release_draw", 32'(draw), 32'd1);
    check("bp_release_x", 32'(x), 32'hFFF);
    enable = 1'b0;
    wait_ev("bp_stop", EV_IDLE, 20, n);
    m_pc = 0;

    // HALT list
    mem[0] = mk(2'b01, 12'h001, 12'h001);
    mem[1] = mk(2'b11, 12'h000, 12'h000);
    enable = 1'b1;
    draws = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (draw) draws++;
      if (halted) break;
    end
    check("halt_draw_count", 32'(draws), 32'd1);
    check("halt_set", 32'(halted), 32'd1);
    stray = 0;
    repeat (10) begin
      tick();
      if (jump | draw | mem_rd) stray++;
    end
    check("halt_quiet", 32'(stray), 32'd0);
    check("halt_held", 32'(halted), 32'd1);
    check("halt_busy", 32'(busy), 32'd0);
    enable = 1'b0;
    tick();
    check("halt_clear", 32'(halted), 32'd0);
    m_pc = 0;
    enable = 1'b1;
    tick();
    check("halt_restart_rd", 32'(mem_rd), 32'd1);
    check("halt_restart_addr", 32'(mem_addr), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (halted) break;
    end
    check("halt_again", 32'(halted), 32'd1);
    enable = 1'b0;
    tick();
    m_pc = 0;
    mem[0] = mk(2'b00, 12'h100, 12'h200);
    mem[1] = mk(2'b01, 12'hFFF, 12'h000);

    // Wrap-around on the ADDR_W=2 instance
    enable_w = 1'b1;
    k = 0;
    for (int i = 0; i < 40 && k < 4; i++) begin
      tick();
      if (wr_draw) begin
        k++;
        check("wrap_x", 32'(wr_x), 32'(k));
        check("wrap_y", 32'(wr_y), 32'(k + 15));
        check("wrap_fd", 32'(wr_frame_done), 32'(k == 4));
        check("wrap_nojump", 32'(wr_jump), 32'd0);
      end
    end
    check("wrap_draws", 32'(k), 32'd4);
    check("wrap_count", 32'(wr_frame_count), 32'd1);
    wait_ev("wrap_refetch", EV_WRD, 5, n);
    check("wrap_refetch_delay", 32'(n), 32'd1);
    check("wrap_refetch_addr", 32'(wr_mem_addr), 32'd0);
    enable_w = 1'b0;
    wait_ev("wrap_stop", EV_WIDLE, 20, n);
    check("wrap_not_halted", 32'(wr_halted), 32'd0);

    // Asynchronous reset while stalled in ISSUE
    ready = 1'b0;
    enable = 1'b1;
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    check("arst_x", 32'(x), 32'd0);
    check("arst_y", 32'(y), 32'd0);
    check("arst_jump", 32'(jump), 32'd0);
    check("arst_draw", 32'(draw), 32'd0);
    check("arst_mem_rd", 32'(mem_rd), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_count", 32'(frame_count), 32'd0);
    m_pc = 0;
    m_count = 0;
    ready = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    wait_ev("arst_fetch", EV_RD, 5, n);
    check("arst_fetch_delay", 32'(n), 32'd1);
    check("arst_fetch_addr", 32'(mem_addr), 32'd0);
    check("arst_fetch_count", 32'(frame_count), 32'd0);
    wait_ev("arst_strobe", EV_STROBE, 10, n);
    check("arst_jump_after", 32'(jump), 32'd1);
    check("arst_x_after", 32'(x), 32'h100);
    enable = 1'b0;
    wait_ev("final_stop", EV_IDLE, 20, n);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
